alink_tx_sched: RTL and testbench

//  Parametrised TX scheduler for the alink block: dispatches tasks from the TX FIFO to PHY_NUM link channels.

---
 rtl/alink_tx_sched.sv | 268 ++++++++++++++++++++++++++
 tb/tb_alink_tx_sched.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alink_tx_sched.sv
// alink TX scheduler: round-robin dispatch of TX FIFO tasks onto PHY_NUM link
// channels, with per-channel busy timers, early release on report arrival and
// timeout reporting.
// Optional feature macro: ALINK_SCHED_TOUT_STAT_EN builds the saturating
// timeout statistics counter behind tout_cnt; without it tout_cnt is tied to 0.
module alink_tx_sched #(
    parameter int PHY_NUM = 32,
    parameter int TOUT_W  = 32,
    parameter int STAT_W  = 16
) (
    input  logic                      CLK_I,
    input  logic                      RST_I,
    input  logic                      reg_flush,
    input  logic [PHY_NUM-1:0]        reg_chan_en,
    input  logic [TOUT_W-1:0]         reg_tout,
    input  logic                      tx_task_vld,
    output logic                      tx_phy_start,
    output logic [PHY_NUM-1:0]        tx_phy_sel,
    input  logic                      tx_phy_done,
    input  logic                      rx_done,
    input  logic [PHY_NUM-1:0]        rx_done_sel,
    output logic [PHY_NUM-1:0]        reg_busy,
    output logic [PHY_NUM*TOUT_W-1:0] timer_cnt,
    output logic                      tout_evt,
    output logic [PHY_NUM-1:0]        tout_sel,
    output logic [STAT_W-1:0]         tout_cnt
);

    localparam int PTR_W = (PHY_NUM > 1) ? $clog2(PHY_NUM) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [PTR_W-1:0]                 ptr_q, ptr_d;
    logic                             start_q, start_d;
    logic [PHY_NUM-1:0]               sel_q, sel_d;
    logic [PHY_NUM-1:0]               busy_q, busy_d;
    logic [PHY_NUM-1:0][TOUT_W-1:0]   timer_q, timer_d;
    logic                             tout_evt_q;
    logic [PHY_NUM-1:0]               tout_sel_q;

    logic [PHY_NUM-1:0]               elig_s;
    logic [PHY_NUM-1:0]               hi_mask_s;
    logic [PHY_NUM-1:0]               pick_s;
    logic [PHY_NUM-1:0]               grant_oh_s;
    logic [PTR_W-1:0]                 grant_idx_s;
    logic [PTR_W-1:0]                 ptr_next_s;
    logic                             dispatch_s;
    logic [PHY_NUM-1:0]               set_s;
    logic [PHY_NUM-1:0]               expire_s;

    assign elig_s     = reg_chan_en & ~busy_q;
    assign dispatch_s = tx_task_vld & (|elig_s);

    // Mask of channel indices at or above the round-robin pointer.
    always_comb begin
        hi_mask_s = '0;
        for (int j = 0; j < PHY_NUM; j++) begin
            hi_mask_s[j] = (j >= int'(ptr_q));
        end
    end

    // Round-robin pick: lowest eligible index at/after ptr, else wrap to lowest overall.
    always_comb begin
        if (|(elig_s & hi_mask_s)) begin
            pick_s = elig_s & hi_mask_s;
        end else begin
            pick_s = elig_s;
        end
        grant_oh_s = pick_s & (~pick_s + PHY_NUM'(1));
    end

    // Binary index of the granted channel and the pointer value that follows it.
    always_comb begin
        grant_idx_s = '0;
        for (int j = PHY_NUM - 1; j >= 0; j--) begin
            grant_idx_s = pick_s[j] ? PTR_W'(j) : grant_idx_s;
        end
        if (int'(grant_idx_s) == PHY_NUM - 1) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_idx_s + PTR_W'(1);
        end
    end

    // FSM state register; flush aborts any send in progress.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
        end else if (reg_flush) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; done pulses outside SEND are ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (dispatch_s) begin
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (tx_phy_done) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: start pulse, held select and pointer advance on grant.
    always_comb begin
        start_d = 1'b0;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (dispatch_s) begin
                    start_d = 1'b1;
                    sel_d   = grant_oh_s;
                    ptr_d   = ptr_next_s;
                end else begin
                    sel_d   = '0;
                end
            end
            ST_SEND: begin
                if (tx_phy_done) begin
                    sel_d = '0;
                end else begin
                    sel_d = sel_q;
                end
            end
            default: begin
                sel_d = '0;
            end
        endcase
    end

    // Dispatch output and round-robin pointer registers.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            start_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else if (reg_flush) begin
            start_q <= 1'b0;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            start_q <= start_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    // Channel that finished sending this cycle becomes busy (only if still enabled).
    assign set_s = ((state_q == ST_SEND) && tx_phy_done) ? (sel_q & reg_chan_en) : '0;

    // Per-channel busy/timer update: disable > task done > report > countdown.
    always_comb begin
        busy_d   = busy_q;
        timer_d  = timer_q;
        expire_s = '0;
        for (int j = 0; j < PHY_NUM; j++) begin
            if (!reg_chan_en[j]) begin
                busy_d[j]  = 1'b0;
                timer_d[j] = '0;
            end else if (set_s[j]) begin
                busy_d[j]  = 1'b1;
                timer_d[j] = reg_tout;
            end else if (rx_done && rx_done_sel[j] && busy_q[j]) begin
                busy_d[j]  = 1'b0;
                timer_d[j] = '0;
            end else if (busy_q[j] && (timer_q[j] != '0)) begin
                timer_d[j] = timer_q[j] - TOUT_W'(1);
                if (timer_q[j] == TOUT_W'(1)) begin
                    busy_d[j]   = 1'b0;
                    expire_s[j] = 1'b1;
                end else begin
                    busy_d[j]   = 1'b1;
                end
            end else begin
                busy_d[j]  = busy_q[j];
                timer_d[j] = timer_q[j];
            end
        end
    end

    // Busy flags, timers and the registered timeout event.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            busy_q     <= '0;
            timer_q    <= '0;
            tout_evt_q <= 1'b0;
            tout_sel_q <= '0;
        end else if (reg_flush) begin
            busy_q     <= '0;
            timer_q    <= '0;
            tout_evt_q <= 1'b0;
            tout_sel_q <= '0;
        end else begin
            busy_q     <= busy_d;
            timer_q    <= timer_d;
            tout_evt_q <= |expire_s;
            tout_sel_q <= expire_s;
        end
    end

`ifdef ALINK_SCHED_TOUT_STAT_EN
    localparam int PC_W = $clog2(PHY_NUM + 1);

    function automatic logic [PC_W-1:0] popcount(input logic [PHY_NUM-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int j = 0; j < PHY_NUM; j++) begin
            n = n + PC_W'(v[j]);
        end
        return n;
    endfunction

    logic [STAT_W-1:0]      cnt_q, cnt_d;
    logic [STAT_W+PC_W-1:0] cnt_sum_s;

    // Saturating accumulation of all channels expiring this cycle.
    always_comb begin
        cnt_sum_s = {{PC_W{1'b0}}, cnt_q} + {{STAT_W{1'b0}}, popcount(expire_s)};
        if (cnt_sum_s > {{PC_W{1'b0}}, {STAT_W{1'b1}}}) begin
            cnt_d = {STAT_W{1'b1}};
        end else begin
            cnt_d = cnt_sum_s[STAT_W-1:0];
        end
    end

    // Timeout statistics register.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            cnt_q <= '0;
        end else if (reg_flush) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tout_cnt = cnt_q;
`else
    assign tout_cnt = '0;
`endif

    assign tx_phy_start = start_q;
    assign tx_phy_sel   = sel_q;
    assign reg_busy     = busy_q;
    assign timer_cnt    = timer_q;
    assign tout_evt     = tout_evt_q;
    assign tout_sel     = tout_sel_q;

endmodule

// File: tb/tb_alink_tx_sched.sv
// Self-checking bench for alink_tx_sched (PHY_NUM=4): directed scenarios plus
// randomized traffic, every cycle compared against a behavioural model.
module tb_alink_tx_sched;

    localparam int N  = 4;
    localparam int TW = 16;
    localparam int SW = 4;

    logic              CLK_I = 1'b0;
    logic              RST_I;
    logic              reg_flush;
    logic [N-1:0]      reg_chan_en;
    logic [TW-1:0]     reg_tout;
    logic              tx_task_vld;
    logic              tx_phy_start;
    logic [N-1:0]      tx_phy_sel;
    logic              tx_phy_done;
    logic              rx_done;
    logic [N-1:0]      rx_done_sel;
    logic [N-1:0]      reg_busy;
    logic [N*TW-1:0]   timer_cnt;
    logic              tout_evt;
    logic [N-1:0]      tout_sel;
    logic [SW-1:0]     tout_cnt;

    always #5 CLK_I = ~CLK_I;

    alink_tx_sched #(.PHY_NUM(N), .TOUT_W(TW), .STAT_W(SW)) dut (
        .CLK_I        (CLK_I),
        .RST_I        (RST_I),
        .reg_flush    (reg_flush),
        .reg_chan_en  (reg_chan_en),
        .reg_tout     (reg_tout),
        .tx_task_vld  (tx_task_vld),
        .tx_phy_start (tx_phy_start),
        .tx_phy_sel   (tx_phy_sel),
        .tx_phy_done  (tx_phy_done),
        .rx_done      (rx_done),
        .rx_done_sel  (rx_done_sel),
        .reg_busy     (reg_busy),
        .timer_cnt    (timer_cnt),
        .tout_evt     (tout_evt),
        .tout_sel     (tout_sel),
        .tout_cnt     (tout_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit m_busy[N];
    int m_timer[N];
    int m_ptr;
    bit m_send;
    int m_sel;
    bit m_start;
    bit [N-1:0] m_tsel;
    int m_tcnt;

    bit n_busy[N];
    int n_timer[N];
    int n_ptr;
    bit n_send;
    int n_sel;
    bit n_start;
    bit [N-1:0] n_tsel;
    int n_tcnt;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_timer[i] = 0;
        end
        m_ptr = 0; m_send = 1'b0; m_sel = -1; m_start = 1'b0; m_tsel = '0; m_tcnt = 0;
    endtask

    task automatic model_next();
        int c;
        bit found;
        int done_ch;
        int pop;
        if (reg_flush) begin
            for (int i = 0; i < N; i++) begin
                n_busy[i] = 1'b0;
                n_timer[i] = 0;
            end
            n_ptr = 0; n_send = 1'b0; n_sel = -1; n_start = 1'b0; n_tsel = '0; n_tcnt = 0;
        end else begin
            n_start = 1'b0; n_send = m_send; n_sel = m_sel; n_ptr = m_ptr; done_ch = -1;
            if (!m_send) begin
                n_sel = -1;
                if (tx_task_vld) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!found && reg_chan_en[c] && !m_busy[c]) begin
                            found = 1'b1;
                            n_send = 1'b1;
                            n_start = 1'b1;
                            n_sel = c;
                            n_ptr = (c + 1) % N;
                        end
                    end
                end
            end else if (tx_phy_done) begin
                n_send = 1'b0;
                n_sel = -1;
                done_ch = m_sel;
            end
            pop = 0;
            for (int i = 0; i < N; i++) begin
                n_tsel[i] = 1'b0;
                n_busy[i] = m_busy[i];
                n_timer[i] = m_timer[i];
                if (!reg_chan_en[i]) begin
                    n_busy[i] = 1'b0;
                    n_timer[i] = 0;
                end else if (i == done_ch) begin
                    n_busy[i] = 1'b1;
                    n_timer[i] = int'(reg_tout);
                end else if (rx_done && rx_done_sel[i] && m_busy[i]) begin
                    n_busy[i] = 1'b0;
                    n_timer[i] = 0;
                end else if (m_busy[i] && m_timer[i] > 0) begin
                    n_timer[i] = m_timer[i] - 1;
                    if (n_timer[i] == 0) begin
                        n_busy[i] = 1'b0;
                        n_tsel[i] = 1'b1;
                        pop++;
                    end
                end
            end
            n_tcnt = m_tcnt;
`ifdef ALINK_SCHED_TOUT_STAT_EN
            n_tcnt = m_tcnt + pop;
            if (n_tcnt > (1 << SW) - 1) n_tcnt = (1 << SW) - 1;
`endif
        end
    endtask

    task automatic model_commit();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = n_busy[i];
            m_timer[i] = n_timer[i];
        end
        m_ptr = n_ptr; m_send = n_send; m_sel = n_sel; m_start = n_start;
        m_tsel = n_tsel; m_tcnt = n_tcnt;
    endtask

    task automatic compare_all();
        logic [N-1:0]    e_sel;
        logic [N-1:0]    e_busy;
        logic [N*TW-1:0] e_timer;
        e_sel = '0;
        if (m_sel >= 0) e_sel[m_sel] = 1'b1;
        for (int i = 0; i < N; i++) begin
            e_busy[i] = m_busy[i];
            e_timer[i*TW +: TW] = TW'(m_timer[i]);
        end
        check("start", 64'(tx_phy_start), 64'(m_start));
        check("sel", 64'(tx_phy_sel), 64'(e_sel));
        check("busy", 64'(reg_busy), 64'(e_busy));
        check("timer", 64'(timer_cnt), 64'(e_timer));
        check("tout_evt", 64'(tout_evt), 64'(|m_tsel));
        check("tout_sel", 64'(tout_sel), 64'(m_tsel));
        check("tout_cnt", 64'(tout_cnt), 64'(m_tcnt));
    endtask

    // ---------------- stimulus helpers ----------------
    int phy_delay = 3;
    int phy_cnt = 0;
    bit phy_pend = 1'b0;
    logic [N-1:0] grants[$];

    task automatic step();
        model_next();
        @(posedge CLK_I);
        #1;
        model_commit();
        compare_all();
        reg_flush = 1'b0;
        rx_done = 1'b0;
        rx_done_sel = '0;
        tx_phy_done = 1'b0;
        if (tx_phy_start) begin
            phy_cnt = phy_delay;
            phy_pend = 1'b1;
            grants.push_back(tx_phy_sel);
        end else if (phy_cnt > 0) begin
            phy_cnt--;
        end
        if (phy_pend && phy_cnt == 0) begin
            tx_phy_done = 1'b1;
            phy_pend = 1'b0;
        end
    endtask

    task automatic wait_start(input string tag);
        int k;
        k = 0;
        while (!tx_phy_start && k < 100) begin
            step();
            k++;
        end
        check(tag, 64'(tx_phy_start), 64'd1);
    endtask

    task automatic wait_busy(input string tag, input int ch);
        int k;
        k = 0;
        while (!reg_busy[ch] && k < 100) begin
            step();
            k++;
        end
        check(tag, 64'(reg_busy[ch]), 64'd1);
    endtask

    task automatic do_flush();
        reg_flush = 1'b1;
        tx_task_vld = 1'b0;
        step();
        phy_pend = 1'b0;
        phy_cnt = 0;
        tx_phy_done = 1'b0;
        grants.delete();
    endtask

    localparam logic [63:0] ONE_TOUT =
`ifdef ALINK_SCHED_TOUT_STAT_EN
        64'd1;
`else
        64'd0;
`endif

    int cnt;
    bit got_evt;
    logic [N-1:0] exp_g[5];

    initial begin
        RST_I = 1'b1;
        reg_flush = 1'b0; reg_chan_en = '0; reg_tout = '0; tx_task_vld = 1'b0;
        tx_phy_done = 1'b0; rx_done = 1'b0; rx_done_sel = '0;
        model_reset();
        repeat (2) @(posedge CLK_I);
        #1;
        check("rst_start", 64'(tx_phy_start), 64'd0);
        check("rst_sel", 64'(tx_phy_sel), 64'd0);
        check("rst_busy", 64'(reg_busy), 64'd0);
        check("rst_timer", 64'(timer_cnt), 64'd0);
        check("rst_tout", 64'(tout_evt), 64'd0);
        check("rst_cnt", 64'(tout_cnt), 64'd0);
        RST_I = 1'b0;

        // Scenario 1/2: full rotation with timeout 10, done 3 cycles after start.
        reg_chan_en = 4'b1111; reg_tout = 16'd10; tx_task_vld = 1'b1; phy_delay = 3;
        cnt = 0; got_evt = 1'b0;
        for (int c = 0; c < 200 && !got_evt; c++) begin
            step();
            if (reg_busy[0]) cnt++;
            if (tout_evt) begin
                got_evt = 1'b1;
                check("t2_tout_sel", 64'(tout_sel), 64'd1);
                check("t2_tout_cnt", 64'(tout_cnt), ONE_TOUT);
            end
        end
        check("t2_evt_seen", 64'(got_evt), 64'd1);
        check("t2_busy0_len", 64'(cnt), 64'd10);
        for (int c = 0; c < 100 && grants.size() < 5; c++) step();
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        check("t1_ngrants", 64'(grants.size() >= 5), 64'd1);
        for (int g = 0; g < 5 && g < grants.size(); g++) check("t1_grant", 64'(grants[g]), 64'(exp_g[g]));

        // Scenario 3: early release by report, channel usable again.
        do_flush();
        reg_chan_en = 4'b0001; reg_tout = 16'd10; tx_task_vld = 1'b1;
        wait_start("t3_start");
        tx_task_vld = 1'b0;
        wait_busy("t3_busy", 0);
        repeat (3) step();
        rx_done = 1'b1; rx_done_sel = 4'b0001;
        step();
        check("t3_rel_busy", 64'(reg_busy[0]), 64'd0);
        check("t3_rel_timer", 64'(timer_cnt[TW-1:0]), 64'd0);
        check("t3_no_tout", 64'(tout_evt), 64'd0);
        tx_task_vld = 1'b1;
        wait_start("t3_restart");
        check("t3_resel", 64'(tx_phy_sel), 64'd1);
        tx_task_vld = 1'b0;
        repeat (20) step();

        // Scenario 4: sparse enable mask, then disable a busy channel.
        do_flush();
        reg_chan_en = 4'b1010; reg_tout = 16'd10; tx_task_vld = 1'b1;
        for (int c = 0; c < 100 && grants.size() < 3; c++) step();
        check("t4_ngrants", 64'(grants.size() >= 3), 64'd1);
        exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010;
        for (int g = 0; g < 3 && g < grants.size(); g++) check("t4_grant", 64'(grants[g]), 64'(exp_g[g]));
        tx_task_vld = 1'b0;
        wait_busy("t4_busy1", 1);
        reg_chan_en = 4'b1000;
        step();
        check("t4_en_clr_busy", 64'(reg_busy[1]), 64'd0);
        check("t4_en_clr_timer", 64'(timer_cnt[TW +: TW]), 64'd0);

        // Scenario 5: zero timeout holds busy until report or disable.
        do_flush();
        reg_chan_en = 4'b1111; reg_tout = 16'd0; tx_task_vld = 1'b1;
        wait_start("t5_start");
        tx_task_vld = 1'b0;
        wait_busy("t5_busy", 0);
        cnt = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            if (reg_busy[0]) cnt++;
        end
        check("t5_hold", 64'(cnt), 64'd1000);
        rx_done = 1'b1; rx_done_sel = 4'b0001;
        step();
        check("t5_rx_rel", 64'(reg_busy[0]), 64'd0);
        tx_task_vld = 1'b1;
        wait_start("t5_start2");
        tx_task_vld = 1'b0;
        wait_busy("t5_busy1", 1);
        repeat (50) step();
        reg_chan_en = 4'b1101;
        step();
        check("t5_en_rel", 64'(reg_busy[1]), 64'd0);

        // Scenario 6: flush during SEND, late done ignored, then async reset.
        do_flush();
        reg_chan_en = 4'b1111; reg_tout = 16'd10; tx_task_vld = 1'b1;
        wait_start("t6_start");
        tx_task_vld = 1'b0;
        reg_flush = 1'b1;
        step();
        check("t6_flush_sel", 64'(tx_phy_sel), 64'd0);
        repeat (6) step();
        check("t6_busy_after_done", 64'(reg_busy), 64'd0);
        tx_task_vld = 1'b1;
        wait_start("t6_start_ptr0");
        check("t6_sel_ptr0", 64'(tx_phy_sel), 64'd1);
        tx_task_vld = 1'b0;
        wait_busy("t6_busy0", 0);
        repeat (3) step();
        #2;
        RST_I = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("t6_async_busy", 64'(reg_busy), 64'd0);
        #1;
        RST_I = 1'b0;
        phy_pend = 1'b0; phy_cnt = 0; tx_phy_done = 1'b0;
        step();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            tx_task_vld = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) reg_chan_en = N'($urandom);
            if ($urandom_range(0, 99) == 0) reg_tout = TW'($urandom_range(0, 15));
            phy_delay = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                rx_done = 1'b1;
                rx_done_sel = N'(1) << $urandom_range(0, N - 1);
            end
            if ($urandom_range(0, 199) == 0) reg_flush = 1'b1;
            if ($urandom_range(0, 99) == 0) tx_phy_done = 1'b1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
